// File: rtl/user_gpio_wb_pkg.sv
// Register offsets, register-index decode and byte-lane helpers shared by the GPIO block.
package user_gpio_pkg;

  localparam logic [7:0] OFF_DOUT    = 8'h00;
  localparam logic [7:0] OFF_OEB     = 8'h04;
  localparam logic [7:0] OFF_DIN     = 8'h08;
  localparam logic [7:0] OFF_RISE_EN = 8'h0C;
  localparam logic [7:0] OFF_FALL_EN = 8'h10;
  localparam logic [7:0] OFF_STATUS  = 8'h14;
  localparam logic [7:0] OFF_ID      = 8'h18;

  // ID bit that advertises the edge-interrupt logic
  localparam int ID_IRQ_BIT = 31;

  typedef enum logic [2:0] {
    REG_DOUT, REG_OEB, REG_DIN, REG_RISE_EN, REG_FALL_EN, REG_STATUS, REG_ID, REG_NONE
  } reg_idx_e;

  function automatic reg_idx_e reg_decode(input logic [7:0] off);
    case (off)
      OFF_DOUT:    return REG_DOUT;
      OFF_OEB:     return REG_OEB;
      OFF_DIN:     return REG_DIN;
      OFF_RISE_EN: return REG_RISE_EN;
      OFF_FALL_EN: return REG_FALL_EN;
      OFF_STATUS:  return REG_STATUS;
      OFF_ID:      return REG_ID;
      default:     return REG_NONE;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/user_gpio_wb_if.sv
// Wishbone classic slave bundle between the wrapper's WB port and the GPIO block.
// Handshake: a request is cyc & stb with a decoded address; the slave answers with a
// single-cycle ack carrying read data, and ignores the bus during that ack cycle.
interface user_gpio_wb_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/user_gpio_wb_sync_edge.sv
// Two-flop synchroniser for asynchronous pad inputs; with GPIO_IRQ_EN it adds a
// previous-value flop and per-bit rise/fall strobes.
module gpio_sync_edge #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] sync
`ifdef GPIO_IRQ_EN
    ,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
`endif
);

    logic [W-1:0] s1_q, s2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= din_i;
            s2_q <= s1_q;
        end
    end

    assign sync = s2_q;

`ifdef GPIO_IRQ_EN
    logic [W-1:0] prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) prev_q <= '0;
        else       prev_q <= s2_q;
    end

    assign rise = s2_q & ~prev_q;
    assign fall = ~s2_q & prev_q;
`endif

endmodule

// File: rtl/user_gpio_wb.sv
// Wishbone GPIO controller: output/enable registers, synchronised input readback and,
// when GPIO_IRQ_EN is defined, per-pin edge interrupts with W1C status.
module user_gpio_wb
    import user_gpio_pkg::*;
#(
    parameter int          NPINS    = 12,
    parameter logic [31:0] ADR_BASE = 32'h3000_0000,
    parameter logic [31:0] ID_VALUE = 32'h4750_0001
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    user_gpio_wb_if.slave     wbs,
    input  logic [NPINS-1:0]  io_in,
    output logic [NPINS-1:0]  io_out,
    output logic [NPINS-1:0]  io_oeb,
    output logic              irq
);

`ifdef GPIO_IRQ_EN
    localparam logic IRQ_FLAG = 1'b1;
`else
    localparam logic IRQ_FLAG = 1'b0;
`endif

    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic [NPINS-1:0]  dout_q, dout_d;
    logic [NPINS-1:0]  oeb_q, oeb_d;
    logic [NPINS-1:0]  din;
    logic              req, wr;
    reg_idx_e          idx;
    logic [31:0]       mask32, rd;
    logic [NPINS-1:0]  wmask, wdata;

`ifdef GPIO_IRQ_EN
    logic [NPINS-1:0]  rise, fall;
    logic [NPINS-1:0]  rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [NPINS-1:0]  status_q, status_d;
    logic              irq_q, irq_d;
`endif

    gpio_sync_edge #(.W(NPINS)) u_sync (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .din_i (io_in),
        .sync  (din)
`ifdef GPIO_IRQ_EN
        ,
        .rise  (rise),
        .fall  (fall)
`endif
    );

    // The ack cycle blocks re-sampling, so a held strobe is answered every other cycle.
    always_comb begin
        req    = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q &
                 (wbs.wbs_adr_i[31:8] == ADR_BASE[31:8]);
        wr     = req & wbs.wbs_we_i;
        idx    = reg_decode({wbs.wbs_adr_i[7:2], 2'b00});
        mask32 = lane_mask(wbs.wbs_sel_i);
        wmask  = mask32[NPINS-1:0];
        wdata  = wbs.wbs_dat_i[NPINS-1:0];
        rd     = '0;
        case (idx)
            REG_DOUT:    rd[NPINS-1:0] = dout_q;
            REG_OEB:     rd[NPINS-1:0] = oeb_q;
            REG_DIN:     rd[NPINS-1:0] = din;
`ifdef GPIO_IRQ_EN
            REG_RISE_EN: rd[NPINS-1:0] = rise_en_q;
            REG_FALL_EN: rd[NPINS-1:0] = fall_en_q;
            REG_STATUS:  rd[NPINS-1:0] = status_q;
`endif
            REG_ID: begin
                rd             = ID_VALUE;
                rd[ID_IRQ_BIT] = IRQ_FLAG;
            end
            default: ;
        endcase
        ack_d  = req;
        dat_d  = req ? rd : '0;
        dout_d = dout_q;
        oeb_d  = oeb_q;
        if (wr && idx == REG_DOUT) dout_d = (dout_q & ~wmask) | (wdata & wmask);
        if (wr && idx == REG_OEB)  oeb_d  = (oeb_q  & ~wmask) | (wdata & wmask);
    end

`ifdef GPIO_IRQ_EN
    // Clear first, then set, so an edge landing with a W1C of the same bit survives.
    always_comb begin
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        status_d  = status_q;
        if (wr && idx == REG_RISE_EN) rise_en_d = (rise_en_q & ~wmask) | (wdata & wmask);
        if (wr && idx == REG_FALL_EN) fall_en_d = (fall_en_q & ~wmask) | (wdata & wmask);
        if (wr && idx == REG_STATUS)  status_d  = status_q & ~(wdata & wmask);
        status_d = status_d | (rise & rise_en_q) | (fall & fall_en_q);
        irq_d    = |status_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            irq_q     <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q  <= 1'b0;
            dat_q  <= '0;
            dout_q <= '0;
            oeb_q  <= '1;
        end else begin
            ack_q  <= ack_d;
            dat_q  <= dat_d;
            dout_q <= dout_d;
            oeb_q  <= oeb_d;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign io_out        = dout_q;
    assign io_oeb        = oeb_q;

    logic unused_ok;
    assign unused_ok = ^{wbs.wbs_adr_i[1:0], mask32, wbs.wbs_dat_i, wbs.wbs_sel_i};

endmodule

// File: tb/tb_user_gpio_wb.sv
// Directed bench for user_gpio_wb: register table plus ack, edge/irq and reset sequences;
// expectations follow GPIO_IRQ_EN.
module tb_user_gpio_wb;
  localparam int          NPINS    = 12;
  localparam logic [31:0] ADR_BASE = 32'h3000_0000;
  localparam logic [31:0] ID_VALUE = 32'h4750_0001;
`ifdef GPIO_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  localparam logic [31:0] ID_EXP = IRQ ? (ID_VALUE | 32'h8000_0000) : ID_VALUE;

  logic clk = 1'b0;
  logic rst;
  logic [NPINS-1:0] io_in, io_out, io_oeb;
  logic irq;

  user_gpio_wb_if bus ();

  user_gpio_wb #(.NPINS(NPINS), .ADR_BASE(ADR_BASE), .ID_VALUE(ID_VALUE)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (bus),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // results of the last bus transfer
  logic [31:0]      rd_dat;
  int               rd_lat;
  logic [NPINS-1:0] ack_io_out, ack_io_oeb;
  logic             ack_irq;

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat);
    @(negedge clk);
    for (int i = 0; i < 4 && bus.wbs_ack_o; i++) @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_sel_i = sel;
    bus.wbs_dat_i = dat;
    rd_lat = 0;
    rd_dat = '0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) begin
        rd_lat     = i;
        rd_dat     = bus.wbs_dat_o;
        ack_io_out = io_out;
        ack_io_oeb = io_oeb;
        ack_irq    = irq;
        break;
      end
    end
    bus_idle();
  endtask

  task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
    wb_xfer(1'b0, ADR_BASE | {24'h0, off}, 4'hF, 32'h0);
    check({name, "_lat"}, rd_lat, 1);
    check(name, rd_dat, exp);
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  off;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        chk;
    logic [31:0] exp;
    logic [11:0] eio;
    logic [11:0] eoeb;
  } vec_t;

  vec_t tbl[25];
  int   acks, consec;
  logic prev_ack;

  initial begin
    rst = 1'b1;
    io_in = 12'h800;
    bus_idle();
    bus.wbs_adr_i = '0;
    bus.wbs_sel_i = '0;
    bus.wbs_dat_i = '0;

    tbl[0]  = '{1'b0, 8'h04, 4'hF, 32'h0,        1'b1, 32'h0000_0FFF, 12'h000, 12'hFFF};
    tbl[1]  = '{1'b0, 8'h00, 4'hF, 32'h0,        1'b1, 32'h0,         12'h000, 12'hFFF};
    tbl[2]  = '{1'b0, 8'h18, 4'hF, 32'h0,        1'b1, ID_EXP,        12'h000, 12'hFFF};
    tbl[3]  = '{1'b0, 8'h08, 4'hF, 32'h0,        1'b1, 32'h0000_0800, 12'h000, 12'hFFF};
    tbl[4]  = '{1'b1, 8'h00, 4'h1, 32'h0000_0A5A,1'b0, 32'h0,         12'h05A, 12'hFFF};
    tbl[5]  = '{1'b0, 8'h00, 4'hF, 32'h0,        1'b1, 32'h0000_005A, 12'h05A, 12'hFFF};
    tbl[6]  = '{1'b1, 8'h00, 4'h2, 32'hFFFF_FA5A,1'b0, 32'h0,         12'hA5A, 12'hFFF};
    tbl[7]  = '{1'b0, 8'h00, 4'hF, 32'h0,        1'b1, 32'h0000_0A5A, 12'hA5A, 12'hFFF};
    tbl[8]  = '{1'b1, 8'h00, 4'hF, 32'h0000_0123,1'b0, 32'h0,         12'h123, 12'hFFF};
    tbl[9]  = '{1'b0, 8'h00, 4'hF, 32'h0,        1'b1, 32'h0000_0123, 12'h123, 12'hFFF};
    tbl[10] = '{1'b1, 8'h04, 4'hF, 32'h0000_00F0,1'b0, 32'h0,         12'h123, 12'h0F0};
    tbl[11] = '{1'b0, 8'h04, 4'hF, 32'h0,        1'b1, 32'h0000_00F0, 12'h123, 12'h0F0};
    tbl[12] = '{1'b1, 8'h04, 4'hF, 32'hFFFF_FFFF,1'b0, 32'h0,         12'h123, 12'hFFF};
    tbl[13] = '{1'b0, 8'h04, 4'hF, 32'h0,        1'b1, 32'h0000_0FFF, 12'h123, 12'hFFF};
    tbl[14] = '{1'b1, 8'h0C, 4'hF, 32'h0000_0123,1'b0, 32'h0,         12'h123, 12'hFFF};
    tbl[15] = '{1'b0, 8'h0C, 4'hF, 32'h0,        1'b1, IRQ ? 32'h123 : 32'h0, 12'h123, 12'hFFF};
    tbl[16] = '{1'b1, 8'h10, 4'h2, 32'hFFFF_FF00,1'b0, 32'h0,         12'h123, 12'hFFF};
    tbl[17] = '{1'b0, 8'h10, 4'hF, 32'h0,        1'b1, IRQ ? 32'hF00 : 32'h0, 12'h123, 12'hFFF};
    tbl[18] = '{1'b0, 8'h14, 4'hF, 32'h0,        1'b1, 32'h0,         12'h123, 12'hFFF};
    tbl[19] = '{1'b1, 8'h1C, 4'hF, 32'hFFFF_FFFF,1'b0, 32'h0,         12'h123, 12'hFFF};
    tbl[20] = '{1'b0, 8'h1C, 4'hF, 32'h0,        1'b1, 32'h0,         12'h123, 12'hFFF};
    tbl[21] = '{1'b1, 8'h40, 4'hF, 32'hFFFF_FFFF,1'b0, 32'h0,         12'h123, 12'hFFF};
    tbl[22] = '{1'b0, 8'h40, 4'hF, 32'h0,        1'b1, 32'h0,         12'h123, 12'hFFF};
    tbl[23] = '{1'b0, 8'hFC, 4'hF, 32'h0,        1'b1, 32'h0,         12'h123, 12'hFFF};
    tbl[24] = '{1'b0, 8'h18, 4'hF, 32'h0,        1'b1, ID_EXP,        12'h123, 12'hFFF};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state and silence without a request
    #1;
    check("rst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
    check("rst_dat", bus.wbs_dat_o, 32'h0);
    check("rst_io_out", {20'h0, io_out}, 32'h0);
    check("rst_io_oeb", {20'h0, io_oeb}, 32'hFFF);
    check("rst_irq", {31'h0, irq}, 32'h0);
    acks = 0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_adr_i = ADR_BASE;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) acks++;
    end
    bus_idle();
    check("no_req_ack", acks, 0);

    for (int i = 0; i < 25; i++) begin
      wb_xfer(tbl[i].we, ADR_BASE | {24'h0, tbl[i].off}, tbl[i].sel, tbl[i].dat);
      check($sformatf("v%0d_lat", i), rd_lat, 1);
      if (tbl[i].chk) check($sformatf("v%0d_dat", i), rd_dat, tbl[i].exp);
      check($sformatf("v%0d_io_out", i), {20'h0, ack_io_out}, {20'h0, tbl[i].eio});
      check($sformatf("v%0d_io_oeb", i), {20'h0, ack_io_oeb}, {20'h0, tbl[i].eoeb});
    end

    // held strobe: single-cycle acks on alternate cycles
    @(negedge clk); @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = ADR_BASE;
    acks = 0; consec = 0; prev_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) acks++;
      if (bus.wbs_ack_o && prev_ack) consec++;
      prev_ack = bus.wbs_ack_o;
    end
    @(negedge clk);
    bus_idle();
    check("held_acks", acks, 4);
    check("held_consec", consec, 0);

    // out-of-window write and cyc without stb
    @(negedge clk); @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_adr_i = ADR_BASE + 32'h100;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_dat_i = 32'hFFF;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) acks++;
    end
    bus.wbs_adr_i = ADR_BASE;
    bus.wbs_stb_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) acks++;
    end
    bus_idle();
    check("unsel_acks", acks, 0);
    rd_chk("unsel_dout", 8'h00, 32'h123);

    // rise on pin 0 -> status -> irq, then W1C
    wb_xfer(1'b1, ADR_BASE | 32'h0C, 4'hF, 32'h001);
    wb_xfer(1'b1, ADR_BASE | 32'h10, 4'hF, 32'h800);
    wb_xfer(1'b1, ADR_BASE | 32'h14, 4'hF, 32'hFFF);
    rd_chk("st_clear", 8'h14, 32'h0);
    check("irq_idle", {31'h0, irq}, 32'h0);
    @(negedge clk);
    io_in[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("irq_e2", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    check("irq_e3", {31'h0, irq}, {31'h0, IRQ});
    rd_chk("din_rise", 8'h08, 32'h801);
    rd_chk("st_rise", 8'h14, IRQ ? 32'h001 : 32'h0);
    wb_xfer(1'b1, ADR_BASE | 32'h14, 4'hF, 32'h001);
    check("w1c_lat", rd_lat, 1);
    check("irq_w1c_ack", {31'h0, ack_irq}, {31'h0, IRQ});
    @(posedge clk); #1;
    check("irq_w1c_after", {31'h0, irq}, 32'h0);

    // fall on pin 11 lands in the same cycle as its W1C: set wins
    @(negedge clk);
    io_in[11] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_adr_i = ADR_BASE | 32'h14;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_dat_i = 32'h800;
    @(posedge clk); #1;
    check("race_ack", {31'h0, bus.wbs_ack_o}, 32'h1);
    bus_idle();
    rd_chk("st_race", 8'h14, IRQ ? 32'h800 : 32'h0);
    check("irq_race", {31'h0, irq}, {31'h0, IRQ});
    wb_xfer(1'b1, ADR_BASE | 32'h10, 4'hF, 32'h0);
    rd_chk("st_en_off", 8'h14, IRQ ? 32'h800 : 32'h0);

    // reset on a pending write
    @(negedge clk); @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_adr_i = ADR_BASE;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_dat_i = 32'hFFF;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
    @(negedge clk);
    bus_idle();
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ack2", {31'h0, bus.wbs_ack_o}, 32'h0);
    check("rst_mid_io_out", {20'h0, io_out}, 32'h0);
    check("rst_mid_irq", {31'h0, irq}, 32'h0);
    rd_chk("rst_mid_dout", 8'h00, 32'h0);
    rd_chk("rst_mid_status", 8'h14, 32'h0);
    rd_chk("rst_mid_oeb", 8'h04, 32'hFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
